// File: rtl/if_fetch_pkg.sv
// Shared constants for the instruction-fetch stage: FSM encodings, word/byte
// widths and the default reset pc.
package if_fetch_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_REQ  = 2'd1;
  localparam fetch_state_t ST_WAIT = 2'd2;
  localparam fetch_state_t ST_PUSH = 2'd3;

  // Byte address of byte k of the word at pc; wraps at 2^32.
  function automatic logic [WORD_W-1:0] byte_addr(input logic [WORD_W-1:0] pc,
                                                  input logic [1:0]        k);
    return pc + {30'd0, k};
  endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache, one word per line; combinational lookup,
// single-cycle fill. Only the valid bits are reset.
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int IDX_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [29:0]       rd_addr,
  output logic              hit,
  output logic [WORD_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [29:0]       wr_addr,
  input  logic [WORD_W-1:0] wr_data
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic [WORD_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid;

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;

  assign rd_idx = rd_addr[IDX_W-1:0];
  assign rd_tag = rd_addr[29:IDX_W];
  assign wr_idx = wr_addr[IDX_W-1:0];
  assign wr_tag = wr_addr[29:IDX_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_idx] <= wr_data;
      tag_mem[wr_idx]  <= wr_tag;
    end
  end

  assign hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles little-endian words from byte reads and pushes
// {word, pc} into the instruction queue. Define ICACHE_EN to add the icache.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC     = RESET_PC_DEF,
  parameter int                ICACHE_IDX_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jmp_en_i,
  input  logic [WORD_W-1:0] jmp_pc_i,
  input  logic              iq_full_i,
  output logic              iq_add_en_o,
  output logic [WORD_W-1:0] iq_add_data_o,
  output logic [WORD_W-1:0] iq_add_pc_o,
  output logic              mem_req_o,
  output logic [WORD_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [BYTE_W-1:0] mem_rdata_i
);

  fetch_state_t      state;
  logic [1:0]        k;
  logic              drop;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] word_buf;

  logic              cache_hit;
  logic [WORD_W-1:0] cache_data;

  // A read already accepted by the controller but not yet returned must be
  // swallowed after a redirect, otherwise it would land in the new word.
  logic read_in_flight;
  assign read_in_flight = ((state == ST_WAIT) && !mem_rvalid_i) ||
                          ((state == ST_REQ) && mem_gnt_i) ||
                          (drop && !mem_rvalid_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      k     <= 2'd0;
      drop  <= 1'b0;
      pc    <= RESET_PC;
    end else if (rdy) begin
      if (jmp_en_i) begin
        pc    <= jmp_pc_i;
        k     <= 2'd0;
        state <= ST_IDLE;
        drop  <= read_in_flight;
      end else begin
        if (drop && mem_rvalid_i) drop <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (!iq_full_i) begin
              if (cache_hit) begin
                state <= ST_PUSH;
              end else if (!drop) begin
                state <= ST_REQ;
                k     <= 2'd0;
              end
            end
          end
          ST_REQ: begin
            if (mem_gnt_i) state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (mem_rvalid_i) begin
              if (k == 2'd3) begin
                state <= ST_PUSH;
              end else begin
                k     <= k + 2'd1;
                state <= ST_REQ;
              end
            end
          end
          default: begin
            pc    <= pc + 32'd4;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Word assembly; the buffer is only observed while in PUSH, so no reset.
  always_ff @(posedge clk) begin
    if (rdy && !jmp_en_i) begin
      if ((state == ST_WAIT) && mem_rvalid_i) begin
        word_buf[{k, 3'b000} +: BYTE_W] <= mem_rdata_i;
      end else if ((state == ST_IDLE) && !iq_full_i && cache_hit) begin
        word_buf <= cache_data;
      end
    end
  end

`ifdef ICACHE_EN
  logic fill_en;
  assign fill_en = rdy && !rst && !jmp_en_i && (state == ST_WAIT) &&
                   mem_rvalid_i && (k == 2'd3);

  if_icache #(
    .IDX_W(ICACHE_IDX_W)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (pc[31:2]),
    .hit     (cache_hit),
    .rd_data (cache_data),
    .wr_en   (fill_en),
    .wr_addr (pc[31:2]),
    .wr_data ({mem_rdata_i, word_buf[23:0]})
  );
`else
  logic [ICACHE_IDX_W-1:0] unused_idx;
  assign unused_idx = pc[ICACHE_IDX_W+1:2];
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  assign iq_add_en_o   = (state == ST_PUSH);
  assign iq_add_data_o = iq_add_en_o ? word_buf : '0;
  assign iq_add_pc_o   = iq_add_en_o ? pc : '0;
  assign mem_req_o     = (state == ST_REQ);
  assign mem_addr_o    = mem_req_o ? byte_addr(pc, k) : '0;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a byte-wide memory model of selectable
// read latency; the cache scenario runs only when ICACHE_EN is defined.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        jmp_en;
  logic [31:0] jmp_pc;
  logic        iq_full;
  logic        iq_add_en;
  logic [31:0] iq_add_data;
  logic [31:0] iq_add_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .jmp_en_i      (jmp_en),
    .jmp_pc_i      (jmp_pc),
    .iq_full_i     (iq_full),
    .iq_add_en_o   (iq_add_en),
    .iq_add_data_o (iq_add_data),
    .iq_add_pc_o   (iq_add_pc),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_gnt_i     (mem_gnt),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata)
  );

  // 16-byte memory image aliased over the whole address space.
  logic [7:0] mem [16];
  int         lat = 0;
  logic       pend;
  int         cnt;
  logic [7:0] pdata;

  assign mem_gnt = mem_req;

  always @(posedge clk) begin
    if (rst) begin
      pend       <= 1'b0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= 8'h00;
    end else if (rdy) begin
      mem_rvalid <= 1'b0;
      if (pend && cnt <= 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= pdata;
        pend       <= 1'b0;
      end else if (pend) begin
        cnt <= cnt - 1;
      end
      if (mem_req && mem_gnt) begin
        if (lat == 0) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= mem[mem_addr[3:0]];
        end else begin
          pend  <= 1'b1;
          cnt   <= lat;
          pdata <= mem[mem_addr[3:0]];
        end
      end
    end
  end

  int          cyc;
  int          push_cnt;
  logic [31:0] addr_q [$];

  always @(posedge clk) begin
    if (rst) cyc <= 1;
    else     cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (rst)                     push_cnt <= 0;
    else if (rdy && iq_add_en)   push_cnt <= push_cnt + 1;
  end

  always @(posedge clk) begin
    if (!rst && rdy && mem_req && mem_gnt) addr_q.push_back(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    addr_q.delete();
  endtask

  task automatic wait_push(input string tag);
    int i;
    i = 0;
    @(negedge clk);
    while (!iq_add_en && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (!iq_add_en) check({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int i;
    i = 0;
    @(negedge clk);
    while (!mem_req && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (!mem_req) check({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    mem[0]  = 8'h13; mem[1]  = 8'h05; mem[2]  = 8'h10; mem[3]  = 8'h00;
    mem[4]  = 8'h93; mem[5]  = 8'h05; mem[6]  = 8'h20; mem[7]  = 8'h00;
    mem[8]  = 8'h44; mem[9]  = 8'h33; mem[10] = 8'h22; mem[11] = 8'h11;
    mem[12] = 8'hDD; mem[13] = 8'hCC; mem[14] = 8'hBB; mem[15] = 8'hAA;
    rst = 1'b1; rdy = 1'b1; jmp_en = 1'b0; jmp_pc = 32'h0; iq_full = 1'b0;

    // Zero-wait fetch of two words, plus reset output values.
    do_reset();
    check("rst iq_add_en", {31'd0, iq_add_en}, 32'd0);
    check("rst iq_add_data", iq_add_data, 32'd0);
    check("rst iq_add_pc", iq_add_pc, 32'd0);
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    wait_push("t1 push0");
    check("t1 push0 cycle", cyc, 32'd10);
    check("t1 push0 data", iq_add_data, 32'h0010_0513);
    check("t1 push0 pc", iq_add_pc, 32'h0);
    @(negedge clk);
    check("t1 push one cycle", {31'd0, iq_add_en}, 32'd0);
    wait_push("t1 push1");
    check("t1 push1 cycle", cyc, 32'd20);
    check("t1 push1 data", iq_add_data, 32'h0020_0593);
    check("t1 push1 pc", iq_add_pc, 32'h4);
    check("t1 addr count", addr_q.size(), 32'd8);
    if (addr_q.size() >= 4)
      for (int i = 0; i < 4; i++) check("t1 byte addr", addr_q[i], i);

    // Queue-full back-pressure while idle.
    do_reset();
    wait_push("t2 push0");
    iq_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2 no req while full", {31'd0, mem_req}, 32'd0);
    end
    iq_full = 1'b0;
    @(negedge clk);
    check("t2 req after release", {31'd0, mem_req}, 32'd1);
    check("t2 addr after release", mem_addr, 32'h4);

    // Redirect while waiting on byte 2: the late byte must be discarded.
    do_reset();
    lat = 2;
    begin
      int i;
      i = 0;
      while (!(mem_req && mem_addr == 32'h2) && i < 200) begin
        @(negedge clk);
        i++;
      end
      check("t3 reach byte2", mem_addr, 32'h2);
    end
    @(negedge clk);
    jmp_en = 1'b1;
    jmp_pc = 32'h100;
    @(negedge clk);
    jmp_en = 1'b0;
    check("t3 no req after jump", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check("t3 no req during drop", {31'd0, mem_req}, 32'd0);
    wait_req("t3 req");
    check("t3 redirect addr", mem_addr, 32'h100);
    wait_push("t3 push");
    check("t3 push pc", iq_add_pc, 32'h100);
    check("t3 push data", iq_add_data, 32'h0010_0513);
    check("t3 no stale push", push_cnt, 32'd0);
    lat = 0;

    // Global stall while pushing.
    do_reset();
    wait_push("t4 push0");
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4 held en", {31'd0, iq_add_en}, 32'd1);
      check("t4 held data", iq_add_data, 32'h0010_0513);
      check("t4 held pc", iq_add_pc, 32'h0);
    end
    rdy = 1'b1;
    @(negedge clk);
    check("t4 en after resume", {31'd0, iq_add_en}, 32'd0);
    check("t4 accepted once", push_cnt, 32'd1);
    wait_push("t4 push1");
    check("t4 next pc", iq_add_pc, 32'h4);

    // Address wrap at the top of memory.
    do_reset();
    jmp_en = 1'b1;
    jmp_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    jmp_en = 1'b0;
    wait_push("t5 push0");
    check("t5 push0 pc", iq_add_pc, 32'hFFFF_FFFC);
    check("t5 push0 data", iq_add_data, 32'hAABB_CCDD);
    check("t5 addr count", addr_q.size(), 32'd4);
    if (addr_q.size() >= 4)
      for (int i = 0; i < 4; i++) check("t5 byte addr", addr_q[i], 32'hFFFF_FFFC + i);
    wait_push("t5 push1");
    check("t5 wrapped pc", iq_add_pc, 32'h0);
    check("t5 wrapped data", iq_add_data, 32'h0010_0513);
    if (addr_q.size() >= 5) check("t5 wrapped addr", addr_q[4], 32'h0);

`ifdef ICACHE_EN
    // Re-fetch of a cached word after a jump.
    do_reset();
    wait_push("t6 fill");
    @(negedge clk);
    jmp_en = 1'b1;
    jmp_pc = 32'h0;
    @(negedge clk);
    jmp_en = 1'b0;
    check("t6 no req on hit", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check("t6 hit push en", {31'd0, iq_add_en}, 32'd1);
    check("t6 hit push pc", iq_add_pc, 32'h0);
    check("t6 hit push data", iq_add_data, 32'h0010_0513);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
